// File: rtl/mm2s_cmd_issuer_if.sv
// mm2s_cmd_issuer_if
// Groups the DataMover MM2S command stream and the read-only tap on the
// returning MM2S data stream.
//   m_axis_mm2s_cmd_tdata  [71:0]  DataMover command word
//   m_axis_mm2s_cmd_tvalid         command valid
//   m_axis_mm2s_cmd_tready         command ready
//   mon_tvalid / mon_tready / mon_tlast  copies of the MM2S data handshake
// master: the command issuer. slave: the DataMover side / data-stream tap.
interface mm2s_cmd_issuer_if;
  logic [71:0] m_axis_mm2s_cmd_tdata;
  logic        m_axis_mm2s_cmd_tvalid;
  logic        m_axis_mm2s_cmd_tready;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;

  modport master (
    output m_axis_mm2s_cmd_tdata,
    output m_axis_mm2s_cmd_tvalid,
    input  m_axis_mm2s_cmd_tready,
    input  mon_tvalid,
    input  mon_tready,
    input  mon_tlast
  );

  modport slave (
    input  m_axis_mm2s_cmd_tdata,
    input  m_axis_mm2s_cmd_tvalid,
    output m_axis_mm2s_cmd_tready,
    output mon_tvalid,
    output mon_tready,
    output mon_tlast
  );
endinterface

// File: rtl/mm2s_cmd_issuer.sv
// mm2s_cmd_issuer
// Splits one (base_addr, total_bytes) descriptor into 72-bit AXI DataMover
// MM2S commands of at most MAX_BTT bytes, limits the number of commands
// whose data has not yet returned (tlast) to MAX_OUTSTANDING, and reports
// completion or error.
// Ports:
//   clock, reset (async, active-low)
//   start, base_addr, total_bytes   descriptor request (sampled in IDLE)
//   bus (master)                    command stream + data-stream monitor tap
//   busy, done, err                 status (done is a 1-cycle pulse, err sticky)
// Optional feature macro MM2S_CMD_STATS_EN adds stat_cmds / stat_beats.
module mm2s_cmd_issuer #(
  parameter int MAX_BTT         = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [31:0]             total_bytes,
  mm2s_cmd_issuer_if.master       bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef MM2S_CMD_STATS_EN
  ,
  output logic [15:0]             stat_cmds,
  output logic [31:0]             stat_beats
`endif
);

  localparam logic [31:0] MAX_BTT_W = 32'(MAX_BTT);
  localparam logic [3:0]  MAX_OUT_W = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_ABORT} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] rem;
  logic [3:0]  outstanding;
  logic [3:0]  tag;
  logic        cmd_tvalid;
  logic [71:0] cmd_tdata;

  logic        acc;
  logic        tl;
  logic        hold;
  logic        stray;
  logic [31:0] cur_btt;
  logic [31:0] addr_n;
  logic [31:0] rem_n;
  logic [3:0]  tag_n;
  logic [3:0]  out_n;

  function automatic logic [71:0] build_cmd(input logic [31:0] a,
                                            input logic [31:0] r,
                                            input logic [3:0]  t);
    logic [22:0] btt;
    btt = (r > MAX_BTT_W) ? MAX_BTT_W[22:0] : r[22:0];
    // {rsvd, TAG, SADDR, DRR=0, EOF=1, DSA=0, Type=INCR, BTT}
    return {4'd0, t, a, 1'b0, 1'b1, 6'd0, 1'b1, btt};
  endfunction

  assign bus.m_axis_mm2s_cmd_tvalid = cmd_tvalid;
  assign bus.m_axis_mm2s_cmd_tdata  = cmd_tdata;

  always_comb begin
    acc     = cmd_tvalid & bus.m_axis_mm2s_cmd_tready;
    hold    = cmd_tvalid & ~bus.m_axis_mm2s_cmd_tready;
    tl      = bus.mon_tvalid & bus.mon_tready & bus.mon_tlast;
    stray   = tl && (outstanding == 4'd0);
    // BTT of the presented command lives in the command word itself.
    cur_btt = {9'd0, cmd_tdata[22:0]};
    addr_n  = acc ? addr + cur_btt : addr;
    rem_n   = acc ? rem - cur_btt : rem;
    tag_n   = tag + {3'd0, acc};
    // Acceptance and tlast in the same cycle cancel out.
    out_n   = outstanding + {3'd0, acc} - {3'd0, tl};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      rem         <= '0;
      outstanding <= '0;
      tag         <= '0;
      cmd_tvalid  <= 1'b0;
      cmd_tdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      tag  <= tag_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr  <= base_addr;
            rem   <= total_bytes;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (stray || addr[3:0] != 4'd0 || rem[3:0] != 4'd0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (rem == 32'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (stray) begin
            err         <= 1'b1;
            busy        <= 1'b0;
            outstanding <= '0;
            // A command already on the bus must still complete its handshake.
            if (hold) begin
              state <= S_ABORT;
            end else begin
              cmd_tvalid <= 1'b0;
              state      <= S_IDLE;
            end
          end else if (state == S_ISSUE) begin
            outstanding <= out_n;
            addr        <= addr_n;
            rem         <= rem_n;
            // Re-evaluate the next command only when nothing is stalled on the bus.
            if (!hold) begin
              cmd_tvalid <= (rem_n != 32'd0) && (out_n < MAX_OUT_W);
              cmd_tdata  <= build_cmd(addr_n, rem_n, tag_n);
            end
            if (acc && rem_n == 32'd0) begin
              state <= S_DRAIN;
            end
          end else begin
            outstanding <= out_n;
            if (out_n == 4'd0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_ABORT: begin
          if (bus.m_axis_mm2s_cmd_tready) begin
            cmd_tvalid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MM2S_CMD_STATS_EN
  logic beat;
  assign beat = bus.mon_tvalid & bus.mon_tready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cmds  <= '0;
      stat_beats <= '0;
    end else if (state == S_IDLE && start) begin
      stat_cmds  <= '0;
      stat_beats <= '0;
    end else begin
      if (acc && stat_cmds != '1)
        stat_cmds <= stat_cmds + 16'd1;
      if (beat && stat_beats != '1)
        stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm2s_cmd_issuer.sv
module tb_mm2s_cmd_issuer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] total_bytes = '0;
  logic        busy, done, err;
`ifdef MM2S_CMD_STATS_EN
  logic [15:0] stat_cmds;
  logic [31:0] stat_beats;
`endif

  mm2s_cmd_issuer_if bus();

  mm2s_cmd_issuer #(.MAX_BTT(4096), .MAX_OUTSTANDING(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .total_bytes (total_bytes),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef MM2S_CMD_STATS_EN
    ,
    .stat_cmds   (stat_cmds),
    .stat_beats  (stat_beats)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  logic [71:0] sb_q[$];
  int          evt_q[$];   // 1 = done pulse, 2 = err rising
  logic [3:0]  exp_tag = '0;
  int          acc_cnt = 0;
  bit          auto_tlast = 1'b0;
  int          credits = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_cmd(input logic [31:0] a, input logic [31:0] btt,
                                         input logic [3:0] t);
    return {4'h0, t, a, 8'h40, 1'b1, btt[22:0]};
  endfunction

  task automatic push_cmds(input logic [31:0] base, input logic [31:0] total);
    logic [31:0] a, r, b;
    a = base;
    r = total;
    while (r != 0) begin
      b = (r > 32'd4096) ? 32'd4096 : r;
      sb_q.push_back(mk_cmd(a, b, exp_tag));
      exp_tag = exp_tag + 4'd1;
      a = a + b;
      r = r - b;
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] t);
    @(posedge clock); #1;
    base_addr   = b;
    total_bytes = t;
    start       = 1'b1;
    @(posedge clock); #1;
    start       = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 3000);
    if (busy) begin
      check("idle_timeout", busy, 1'b0);
    end else begin
      @(posedge clock); #1;
      check("done_width", done, 1'b0);
    end
  endtask

  // Data-stream model: one non-last beat then one tlast beat per accepted command.
  initial begin : data_gen
    int  pend;
    bit  phase;
    pend  = 0;
    phase = 1'b0;
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b1;
    bus.mon_tlast  = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && bus.m_axis_mm2s_cmd_tvalid && bus.m_axis_mm2s_cmd_tready) pend++;
      @(posedge clock); #1;
      if (!reset) begin
        pend  = 0;
        phase = 1'b0;
        bus.mon_tvalid = 1'b0;
        bus.mon_tlast  = 1'b0;
      end else if (pend > 0 && (auto_tlast || credits > 0)) begin
        bus.mon_tvalid = 1'b1;
        bus.mon_tlast  = phase;
        if (phase) begin
          pend--;
          if (!auto_tlast) credits--;
        end
        phase = ~phase;
      end else begin
        bus.mon_tvalid = 1'b0;
        bus.mon_tlast  = 1'b0;
      end
    end
  end

  // Scoreboard monitor: compares every presented command and every status event.
  initial begin : monitor
    bit hold_prev;
    bit err_prev;
    int e;
    hold_prev = 1'b0;
    err_prev  = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_prev = 1'b0;
        err_prev  = 1'b0;
      end else begin
        if (hold_prev) check("tvalid_held", bus.m_axis_mm2s_cmd_tvalid, 1'b1);
        if (bus.m_axis_mm2s_cmd_tvalid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_cmd", bus.m_axis_mm2s_cmd_tdata, 72'h0);
          end else begin
            check("cmd_tdata", bus.m_axis_mm2s_cmd_tdata, sb_q[0]);
            if (bus.m_axis_mm2s_cmd_tready) begin
              void'(sb_q.pop_front());
              acc_cnt++;
            end
          end
        end
        hold_prev = bus.m_axis_mm2s_cmd_tvalid && !bus.m_axis_mm2s_cmd_tready;
        if (done || (err && !err_prev)) begin
          e = (evt_q.size() == 0) ? 0 : evt_q.pop_front();
          check("status_event", done ? 72'd1 : 72'd2, 72'(e));
        end
        err_prev = err;
      end
    end
  end

  initial begin : stim
    int a0;
    logic [3:0] t7tag;
    int n;
    bus.m_axis_mm2s_cmd_tready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tvalid", bus.m_axis_mm2s_cmd_tvalid, 1'b0);
    check("rst_tdata",  bus.m_axis_mm2s_cmd_tdata, 72'h0);
    check("rst_busy",   busy, 1'b0);
    check("rst_done",   done, 1'b0);
    check("rst_err",    err, 1'b0);
    reset = 1'b1;
    bus.m_axis_mm2s_cmd_tready = 1'b1;
    auto_tlast = 1'b1;

    // Three full-size commands.
    sb_q.push_back(72'h00_10000000_40801000);
    sb_q.push_back(72'h01_10001000_40801000);
    sb_q.push_back(72'h02_10002000_40801000);
    exp_tag = 4'd3;
    evt_q.push_back(1);
    do_start(32'h1000_0000, 32'h0000_3000);
    check("t1_busy_during", busy, 1'b1);
    wait_idle();

    // Short tail command.
    sb_q.push_back(72'h03_20000000_40801000);
    sb_q.push_back(72'h04_20001000_40800010);
    exp_tag = 4'd5;
    evt_q.push_back(1);
    do_start(32'h2000_0000, 32'h0000_1010);
    wait_idle();

    // Misaligned base: error two cycles after start, no command.
    evt_q.push_back(2);
    do_start(32'h1000_0004, 32'h0000_0100);
    check("t3_err_cycle1", err, 1'b0);
    @(posedge clock); #1;
    check("t3_err_cycle2", err, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_tvalid", bus.m_axis_mm2s_cmd_tvalid, 1'b0);

    // Zero length: done only, err cleared by the new start.
    evt_q.push_back(1);
    do_start(32'h1000_0000, 32'h0000_0000);
    check("t4_err_cleared", err, 1'b0);
    wait_idle();

    // Outstanding limit of 2 with tlast withheld.
    auto_tlast = 1'b0;
    credits = 0;
    push_cmds(32'h3000_0000, 32'h0000_5000);
    evt_q.push_back(1);
    a0 = acc_cnt;
    do_start(32'h3000_0000, 32'h0000_5000);
    repeat (10) @(posedge clock);
    #1;
    check("t5_accepted_2", 72'(acc_cnt - a0), 72'd2);
    check("t5_tvalid_low", bus.m_axis_mm2s_cmd_tvalid, 1'b0);
    credits = 1;
    repeat (10) @(posedge clock);
    #1;
    check("t5_accepted_3", 72'(acc_cnt - a0), 72'd3);
    check("t5_tvalid_low2", bus.m_axis_mm2s_cmd_tvalid, 1'b0);
    auto_tlast = 1'b1;
    wait_idle();

    // 17 commands: tag wraps 15 -> 0.
    push_cmds(32'h8000_0000, 32'h0001_1000);
    evt_q.push_back(1);
    do_start(32'h8000_0000, 32'h0001_1000);
    wait_idle();

    // Backpressure then asynchronous reset mid-ISSUE.
    bus.m_axis_mm2s_cmd_tready = 1'b0;
    t7tag = exp_tag;
    push_cmds(32'h4000_0000, 32'h0000_2000);
    do_start(32'h4000_0000, 32'h0000_2000);
    n = 0;
    while (!bus.m_axis_mm2s_cmd_tvalid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("t7_tvalid_up", bus.m_axis_mm2s_cmd_tvalid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("t7_hold_tvalid", bus.m_axis_mm2s_cmd_tvalid, 1'b1);
      check("t7_hold_tdata", bus.m_axis_mm2s_cmd_tdata,
            mk_cmd(32'h4000_0000, 32'h1000, t7tag));
    end
    #2;
    reset = 1'b0;
    #1;
    check("t7_async_tvalid", bus.m_axis_mm2s_cmd_tvalid, 1'b0);
    check("t7_async_busy", busy, 1'b0);
    sb_q.delete();
    evt_q.delete();
    exp_tag = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    bus.m_axis_mm2s_cmd_tready = 1'b1;

    // Tag counter restarts at 0 after reset.
    sb_q.push_back(72'h00_50000000_40801000);
    exp_tag = 4'd1;
    evt_q.push_back(1);
    do_start(32'h5000_0000, 32'h0000_1000);
    wait_idle();
`ifdef MM2S_CMD_STATS_EN
    repeat (2) @(posedge clock);
    #1;
    check("stat_cmds", 72'(stat_cmds), 72'd1);
    check("stat_beats", 72'(stat_beats), 72'd2);
`endif

    repeat (5) @(posedge clock);
    #1;
    check("sb_empty", 72'(sb_q.size()), 72'd0);
    check("evt_empty", 72'(evt_q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
